// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR engine sequencer.
package fir_pkg;
  localparam int         TAPE_NUM    = 11;
  localparam int         WORD_STRIDE = 4;
  localparam logic [3:0] WE_ALL      = 4'hF;

  typedef enum logic [2:0] {
    IDLE, CLEAR, WAIT_SS, MAC, OUT, DONE
  } state_t;
endpackage

// File: rtl/fir_addr_gen.sv
// Circular write pointer and tap counter; turns indices into BRAM byte addresses.
module fir_addr_gen
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int Tape_Num    = TAPE_NUM,
  parameter int IDX_W       = $clog2(Tape_Num + 1)
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   wptr_clr,
  input  logic                   wptr_inc,
  input  logic                   k_clr,
  input  logic                   k_inc,
  output logic                   k_last,
  output logic                   k_end,
  output logic [pADDR_WIDTH-1:0] k_addr,
  output logic [pADDR_WIDTH-1:0] rd_addr,
  output logic [pADDR_WIDTH-1:0] wr_addr
);
  localparam logic [pADDR_WIDTH-1:0] STRIDE = pADDR_WIDTH'(WORD_STRIDE);
  localparam logic [IDX_W-1:0]       N_IDX  = IDX_W'(Tape_Num);

  logic [IDX_W-1:0] k, wptr, rd_idx;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      k    <= '0;
      wptr <= '0;
    end else begin
      if (k_clr)      k <= '0;
      else if (k_inc) k <= k + IDX_W'(1);
      if (wptr_clr)      wptr <= '0;
      else if (wptr_inc) wptr <= (wptr == N_IDX - IDX_W'(1)) ? '0 : wptr + IDX_W'(1);
    end
  end

  // (wptr - k) mod Tape_Num; the intermediate may exceed the index range but the result never does
  assign rd_idx  = (wptr >= k) ? wptr - k : wptr + N_IDX - k;
  assign k_last  = (k == N_IDX - IDX_W'(1));
  assign k_end   = (k == N_IDX);
  assign k_addr  = pADDR_WIDTH'(k) * STRIDE;
  assign rd_addr = pADDR_WIDTH'(rd_idx) * STRIDE;
  assign wr_addr = pADDR_WIDTH'(wptr) * STRIDE;
endmodule

// File: rtl/fir_engine_ctrl.sv
// FIR sequencer: stream in, walk tap/data BRAMs, stream out, tap port arbitration.
// Optional ss_tlast consistency check under FIR_ENGINE_CTRL_TLAST_CHECK_EN.
module fir_engine_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = TAPE_NUM
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start,
  input  logic                   ap_done_clr,
  input  logic [31:0]            data_length,
  output logic                   ap_idle,
  output logic                   ap_done,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic [pDATA_WIDTH-1:0] mac_result,
  output logic                   mac_clr,
  output logic                   mac_en,
  input  logic                   cfg_tap_req,
  input  logic                   cfg_tap_we,
  input  logic [pADDR_WIDTH-1:0] cfg_tap_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_tap_wdata,
  output logic                   cfg_tap_gnt,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic                   err_tlast
);
  state_t state, nxt;
  logic [31:0] len_r, out_cnt;
  logic        out_vld, issue, issue_q;
  logic        wptr_clr, wptr_inc, k_clr, k_inc, k_last, k_end;
  logic [pADDR_WIDTH-1:0] k_addr, rd_addr, wr_addr;
  logic        start_acc, last_out;

  fir_addr_gen #(.pADDR_WIDTH(pADDR_WIDTH), .Tape_Num(Tape_Num)) u_addr (
    .axis_clk, .axis_rst, .wptr_clr, .wptr_inc, .k_clr, .k_inc,
    .k_last, .k_end, .k_addr, .rd_addr, .wr_addr
  );

  assign start_acc = (state == IDLE) && ap_start;
  assign last_out  = (out_cnt == len_r - 32'd1);
  assign ap_idle   = (state == IDLE);
  assign sm_tvalid = (state == OUT) && out_vld;
  assign sm_tlast  = sm_tvalid && last_out;
  assign mac_en    = issue_q;

  always_comb begin
    nxt = state;
    ss_tready = 1'b0; mac_clr = 1'b0; issue = 1'b0; cfg_tap_gnt = 1'b0;
    tap_EN = 1'b0; tap_WE = '0; tap_A = '0; tap_Di = '0;
    data_EN = 1'b0; data_WE = '0; data_A = '0; data_Di = '0;
    wptr_clr = 1'b0; wptr_inc = 1'b0; k_clr = 1'b0; k_inc = 1'b0;
    // Outside MAC the AXI-lite side sees the tap port combinationally
    if (state != MAC && cfg_tap_req) begin
      cfg_tap_gnt = 1'b1;
      tap_EN      = 1'b1;
      tap_WE      = cfg_tap_we ? WE_ALL : 4'h0;
      tap_A       = cfg_tap_addr;
      tap_Di      = cfg_tap_wdata;
    end
    case (state)
      IDLE: if (ap_start) begin
        nxt = CLEAR; k_clr = 1'b1; wptr_clr = 1'b1;
      end
      CLEAR: begin
        data_EN = 1'b1; data_WE = WE_ALL; data_A = k_addr; k_inc = 1'b1;
        if (k_last) nxt = (len_r == 32'd0) ? DONE : WAIT_SS;
      end
      WAIT_SS: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN = 1'b1; data_WE = WE_ALL; data_A = wr_addr; data_Di = ss_tdata;
          mac_clr = 1'b1; k_clr = 1'b1; nxt = MAC;
        end
      end
      MAC: begin
        if (!k_end) begin
          issue = 1'b1; k_inc = 1'b1;
          tap_EN = 1'b1; tap_A = k_addr;
          data_EN = 1'b1; data_A = rd_addr;
        end else begin
          nxt = OUT;
        end
      end
      OUT: if (sm_tvalid && sm_tready) begin
        wptr_inc = 1'b1;
        nxt = (out_cnt + 32'd1 == len_r) ? DONE : WAIT_SS;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state <= IDLE; ap_done <= 1'b0; len_r <= '0; out_cnt <= '0;
      out_vld <= 1'b0; issue_q <= 1'b0; sm_tdata <= '0;
    end else begin
      state   <= nxt;
      issue_q <= issue;
      if (start_acc) begin
        len_r   <= data_length;
        out_cnt <= '0;
      end
      if (state == DONE)                 ap_done <= 1'b1;
      else if (ap_done_clr || start_acc) ap_done <= 1'b0;
      // First OUT cycle lets the final accumulate land before capturing it
      if (state == OUT) begin
        if (!out_vld) begin
          sm_tdata <= mac_result;
          out_vld  <= 1'b1;
        end else if (sm_tready) begin
          out_vld <= 1'b0;
          out_cnt <= out_cnt + 32'd1;
        end
      end
    end
  end

`ifdef FIR_ENGINE_CTRL_TLAST_CHECK_EN
  always_ff @(posedge axis_clk) begin
    if (axis_rst || start_acc) err_tlast <= 1'b0;
    else if (state == WAIT_SS && ss_tvalid && (ss_tlast != last_out)) err_tlast <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = ss_tlast;
  assign err_tlast    = 1'b0;
`endif
endmodule
